// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and default width for the bit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_fs_bit_cell.sv
// fs_bit_cell: one-bit full subtractor, purely combinational
// Ports: a, b, borrow_in -> diff = a ^ b ^ borrow_in, borrow_out = borrow generated or propagated
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b over WIDTH cycles with registered result
// Ports: clk, rst_n (sync, active-low), start/a/b request, busy/done status,
//        diff/borrow_out result; ovf (signed overflow) only with SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             w_d, w_bo, w_last, w_accept;

    fs_bit_cell u_cell (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrow_in  (r_borrow),
        .diff       (w_d),
        .borrow_out (w_bo)
    );

    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = r_state != IDLE;
        done   = r_state == DONE;
        if (w_accept)                        w_next = SHIFT;
        else if (r_state == SHIFT && w_last) w_next = DONE;
        else if (r_state == DONE)            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf        <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_bo;
            r_acc    <= {w_d, r_acc[WIDTH-1:1]};
            // hold on the last bit so the counter never wraps inside an operation
            r_cnt    <= w_last ? r_cnt : r_cnt + 1'b1;
            if (w_last) begin
                diff       <= {w_d, r_acc[WIDTH-1:1]};
                borrow_out <= w_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                // on the last bit the operand LSBs are the original sign bits
                ovf        <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk, rst_n, start;
    logic [W-1:0] a, b, diff;
    logic         busy, done, borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] prev_d;
    logic         prev_b, prev_o;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle; the operation is accepted at the next edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit hold, input bit scramble);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           sr;
        ed = ta - tb;
        eb = ta < tb;
        sr = $signed(ta) - $signed(tb);
        eo = (sr > 127) || (sr < -128);
        a = ta;
        b = tb;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 1; k < W; k++) begin
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            chk("shift_busy", busy, 1);
            chk("shift_done", done, 0);
            chk("shift_diff_hold", diff, prev_d);
            chk("shift_borrow_hold", borrow_out, prev_b);
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("diff", diff, ed);
        chk("borrow", borrow_out, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", ovf, eo);
`endif
        prev_d = ed;
        prev_b = eb;
        prev_o = eo;
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_diff_hold", diff, prev_d);
        chk("idle_borrow_hold", borrow_out, prev_b);
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        prev_d = '0;
        prev_b = 1'b0;
        prev_o = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b1);
        run_op(8'h10, 8'h20, 1'b0, 1'b0);
        run_op(8'h20, 8'h10, 1'b0, 1'b0);

        a = 8'hFF;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_borrow", borrow_out, 0);
        prev_d = '0;
        prev_b = 1'b0;
        prev_o = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
        end

        start = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("rst_over_start", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op(8'h00, 8'hFF, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
